// File: rtl/envelope_follower_if.sv
// Sample-in / envelope-out handshake bundle for envelope_follower.
// The DUT uses the slave modport; the master modport is the sample source and result sink.
interface envelope_follower_if #(
   parameter int WIDTH    = 24,
   parameter int CHANNELS = 2,
   parameter int COEF_W   = 16,
   parameter int HOLD_W   = 12
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                     in_valid;
   logic                     in_ready;
   logic signed [WIDTH-1:0]  in_sample;
   logic [CH_W-1:0]          in_chan;
   logic [COEF_W-1:0]        attack_coef;
   logic [COEF_W-1:0]        release_coef;
   logic [HOLD_W-1:0]        hold_samples;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_env;
   logic [CH_W-1:0]          out_chan;

   modport slave (
      input  in_valid, in_sample, in_chan, attack_coef, release_coef, hold_samples, out_ready,
      output in_ready, out_valid, out_env, out_chan
   );

   modport master (
      output in_valid, in_sample, in_chan, attack_coef, release_coef, hold_samples, out_ready,
      input  in_ready, out_valid, out_env, out_chan
   );
endinterface

// File: rtl/envelope_follower.sv
// Time-multiplexed per-channel peak envelope follower with separate attack/release smoothing.
// Optional per-channel peak-hold is built when ENVELOPE_PEAK_HOLD_EN is defined.
module envelope_follower #(
   parameter int WIDTH    = 24,
   parameter int CHANNELS = 2,
   parameter int COEF_W   = 16,
   parameter int HOLD_W   = 12
) (
   input  logic               clk,
   input  logic               reset_n,
   envelope_follower_if.slave bus
);
   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PROD_W = WIDTH + COEF_W + 2;

   typedef enum logic [2:0] {IDLE, CALC, MUL, WRITE, OUT} state_t;
   state_t state;

   logic                     in_ready_r;
   logic                     out_valid_r;
   logic [WIDTH-1:0]         out_env_r;
   logic [CH_W-1:0]          out_chan_r;

   logic signed [WIDTH-1:0]  cap_sample;
   logic [CH_W-1:0]          cap_chan;
   logic [COEF_W-1:0]        cap_attack;
   logic [COEF_W-1:0]        cap_release;

   logic [WIDTH-2:0]         env [CHANNELS];
   logic [WIDTH-2:0]         env_r;
   logic signed [WIDTH:0]    diff_r;
   logic [COEF_W-1:0]        coef_r;
   logic signed [PROD_W-1:0] prod_r;

   logic                     chan_ok;
   logic                     diff_pos_c;
   logic                     diff_r_pos;
   logic [WIDTH-2:0]         mag_c;
   logic [WIDTH-2:0]         env_sel_c;
   logic [WIDTH-2:0]         env_next_c;
   logic [WIDTH-2:0]         wr_env_c;
   logic signed [WIDTH:0]    diff_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [PROD_W-1:0] delta_c;

`ifdef ENVELOPE_PEAK_HOLD_EN
   logic [HOLD_W-1:0]        hold [CHANNELS];
   logic [HOLD_W-1:0]        cap_hold;
   logic                     holding_c;
`else
   logic [HOLD_W-1:0]        unused_hold;
   assign unused_hold = bus.hold_samples;
`endif

   always_comb begin
      chan_ok   = int'(cap_chan) < CHANNELS;
      env_sel_c = chan_ok ? env[cap_chan] : '0;
      // Rectify; the most negative code has no positive twin and saturates to full scale.
      if (!cap_sample[WIDTH-1])
         mag_c = cap_sample[WIDTH-2:0];
      else if (cap_sample[WIDTH-2:0] == '0)
         mag_c = '1;
      else
         mag_c = (~cap_sample[WIDTH-2:0]) + (WIDTH-1)'(1);
      diff_c     = $signed({2'b00, mag_c}) - $signed({2'b00, env_sel_c});
      diff_pos_c = !diff_c[WIDTH] && (diff_c != '0);
      diff_r_pos = !diff_r[WIDTH] && (diff_r != '0);

      prod_c  = PROD_W'(diff_r) * PROD_W'($signed({1'b0, coef_r}));
      delta_c = prod_r >>> COEF_W;
      // Small differences would floor to zero forever; step by one so the envelope always converges.
      if (diff_r != '0 && coef_r != '0 && delta_c == '0)
         delta_c = diff_r[WIDTH] ? '1 : PROD_W'(1);
      env_next_c = env_r + delta_c[WIDTH-2:0];

`ifdef ENVELOPE_PEAK_HOLD_EN
      holding_c = !diff_r_pos && (hold[cap_chan] != '0);
      wr_env_c  = holding_c ? env_r : env_next_c;
`else
      wr_env_c  = env_next_c;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_env_r   <= '0;
         out_chan_r  <= '0;
         cap_sample  <= '0;
         cap_chan    <= '0;
         cap_attack  <= '0;
         cap_release <= '0;
         env_r       <= '0;
         diff_r      <= '0;
         coef_r      <= '0;
         prod_r      <= '0;
         for (int i = 0; i < CHANNELS; i++) env[i] <= '0;
`ifdef ENVELOPE_PEAK_HOLD_EN
         cap_hold    <= '0;
         for (int i = 0; i < CHANNELS; i++) hold[i] <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               in_ready_r <= 1'b1;
               if (bus.in_valid && in_ready_r) begin
                  cap_sample  <= bus.in_sample;
                  cap_chan    <= bus.in_chan;
                  cap_attack  <= bus.attack_coef;
                  cap_release <= bus.release_coef;
`ifdef ENVELOPE_PEAK_HOLD_EN
                  cap_hold    <= bus.hold_samples;
`endif
                  in_ready_r  <= 1'b0;
                  state       <= CALC;
               end
            end
            CALC: begin
               if (chan_ok) begin
                  env_r  <= env_sel_c;
                  diff_r <= diff_c;
                  coef_r <= diff_pos_c ? cap_attack : cap_release;
                  state  <= MUL;
               end else begin
                  in_ready_r <= 1'b1;
                  state      <= IDLE;
               end
            end
            MUL: begin
               prod_r <= prod_c;
               state  <= WRITE;
            end
            WRITE: begin
               env[cap_chan] <= wr_env_c;
`ifdef ENVELOPE_PEAK_HOLD_EN
               if (diff_r_pos)
                  hold[cap_chan] <= cap_hold;
               else if (holding_c)
                  hold[cap_chan] <= hold[cap_chan] - HOLD_W'(1);
`endif
               out_env_r   <= {1'b0, wr_env_c};
               out_chan_r  <= cap_chan;
               out_valid_r <= 1'b1;
               state       <= OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_env   = out_env_r;
   assign bus.out_chan  = out_chan_r;

endmodule
